// File: rtl/tx_word_gearbox.sv
// tx_word_gearbox
//   Feeds the TX serializer with one SER_WIDTH-bit slice per clk cycle.
//   Wide words from the link layer are buffered in a small FIFO. Each word is
//   then emitted LSB slice first over RATIO = IN_WIDTH/SER_WIDTH cycles.
//   When no word is ready at a word boundary, idle_pattern is sent instead.
//
//   Handshake: a word transfers on a rising clk edge where in_valid and
//   in_ready are both high. in_ready depends only on FIFO occupancy and rst,
//   never on in_valid. A pop in the same cycle does not free space early.
//
//   Ports:
//     clk           divided serializer clock, rising-edge logic
//     rst           asynchronous reset, active-high
//     enable        allows new words to be popped at word boundaries
//     in_data       IN_WIDTH word from the link layer
//     in_valid      in_data is valid
//     in_ready      FIFO has room (combinational)
//     idle_pattern  slice sent when no payload is available
//     prbs_mode     (TX_GEARBOX_PRBS_EN only) send PRBS7 instead of data
//     dout          registered slice to the serializer din
//     dout_valid    registered, high when dout carries payload
//     busy          FIFO non-empty or a word is still being emitted
//
//   Optional feature macro: TX_GEARBOX_PRBS_EN adds prbs_mode and a PRBS7
//   (x^7+x^6+1) generator.
//   SER_WIDTH defaults to 2**`SERDES_STAGES. SERDES_STAGES falls back to 2
//   when it is not defined elsewhere.

`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

module tx_word_gearbox #(
  parameter int IN_WIDTH   = 32,
  parameter int SER_WIDTH  = 2**`SERDES_STAGES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SER_WIDTH-1:0] idle_pattern,
`ifdef TX_GEARBOX_PRBS_EN
  input  logic                 prbs_mode,
`endif
  output logic [SER_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / SER_WIDTH;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PRBS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IN_WIDTH-1:0]   sh_q, sh_d;
  logic [SER_WIDTH-1:0]  dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [IN_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                  push, pop, boundary, prbs_on;
  logic [IN_WIDTH-1:0]   head;

  assign in_ready = (count_q != CW'(FIFO_DEPTH)) && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign busy     = (count_q != '0) || (state_q == SEND);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  // A word boundary happens in IDLE/PRBS, or on the last slice of a word.
  // Only here are prbs_mode and enable allowed to change what comes next.
  assign boundary = (state_q != SEND) || (idx_q == LAST_IDX);

`ifdef TX_GEARBOX_PRBS_EN
  logic [6:0]           lfsr_q, lfsr_d, lfsr_step;
  logic [SER_WIDTH-1:0] prbs_bits;

  assign prbs_on = prbs_mode;

  // Advance the Fibonacci LFSR SER_WIDTH times. The first generated bit
  // (the oldest) goes to the LSB, matching the serializer bit order.
  always_comb begin
    lfsr_step = lfsr_q;
    prbs_bits = '0;
    for (int i = 0; i < SER_WIDTH; i++) begin
      prbs_bits[i] = lfsr_step[6] ^ lfsr_step[5];
      lfsr_step    = {lfsr_step[5:0], lfsr_step[6] ^ lfsr_step[5]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 7'h7F;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign prbs_on = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sh_d         = sh_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    pop          = 1'b0;
`ifdef TX_GEARBOX_PRBS_EN
    lfsr_d       = lfsr_q;
`endif
    if (boundary) begin
      idx_d = '0;
      if (prbs_on) begin
        state_d      = PRBS;
        dout_valid_d = 1'b0;
`ifdef TX_GEARBOX_PRBS_EN
        dout_d       = prbs_bits;
        lfsr_d       = lfsr_step;
`endif
      end else if (enable && (count_q != '0)) begin
        pop          = 1'b1;
        state_d      = SEND;
        dout_d       = head[SER_WIDTH-1:0];
        sh_d         = head >> SER_WIDTH;
        dout_valid_d = 1'b1;
      end else begin
        state_d      = IDLE;
        dout_d       = idle_pattern;
        dout_valid_d = 1'b0;
      end
    end else begin
      idx_d  = idx_q + 1'b1;
      dout_d = sh_q[SER_WIDTH-1:0];
      sh_d   = sh_q >> SER_WIDTH;
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sh_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_tx_word_gearbox.sv
module tb_tx_word_gearbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  idle_pattern = 4'hA;
  logic        prbs_mode = 1'b0;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_word_gearbox #(
    .IN_WIDTH(32), .SER_WIDTH(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .idle_pattern(idle_pattern),
`ifdef TX_GEARBOX_PRBS_EN
    .prbs_mode(prbs_mode),
`endif
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  // Reference model: a queue of pushed words, plus a queue of slices still
  // owed for the word currently on the wire.
  logic [31:0] m_fifo[$];
  logic [3:0]  m_sl[$];
  logic [3:0]  m_dout = 4'h0;
  logic        m_valid = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_push;
  logic [31:0] m_w;
  int          m_pn = 0;
  logic        prbs_seq [127];
  logic        exp_rdy;

  initial begin
    logic [133:0] t;
    t = '0;
    t[6:0] = 7'h7F;
    for (int n = 0; n < 127; n++) begin
      t[n+7] = t[n] ^ t[n+1];
      prbs_seq[n] = t[n+7];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_sl.delete();
      m_dout  = 4'h0;
      m_valid = 1'b0;
      m_pn    = 0;
    end else begin
      m_push = in_valid && (m_fifo.size() < 4);
      if (m_sl.size() == 0) begin
        if (prbs_mode) begin
          for (int i = 0; i < 4; i++) m_dout[i] = prbs_seq[(m_pn + i) % 127];
          m_pn    = (m_pn + 4) % 127;
          m_valid = 1'b0;
        end else begin
          if (enable && m_fifo.size() != 0) begin
            m_w = m_fifo.pop_front();
            for (int k = 0; k < 8; k++) m_sl.push_back(m_w[k*4 +: 4]);
          end
          if (m_sl.size() != 0) begin
            m_dout  = m_sl.pop_front();
            m_valid = 1'b1;
          end else begin
            m_dout  = idle_pattern;
            m_valid = 1'b0;
          end
        end
      end else begin
        m_dout  = m_sl.pop_front();
        m_valid = 1'b1;
      end
      if (m_push) m_fifo.push_back(in_data);
    end
    m_busy = (m_fifo.size() != 0) || m_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (dout !== 4'h0) begin bad++; $display("FAIL reset dout got=%h exp=0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset dout_valid got=%b exp=0", dout_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready got=%b exp=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (dout !== 4'hA || dout_valid !== 1'b0) begin
      bad++; $display("FAIL reset_idle got=%h/%b exp=a/0", dout, dout_valid);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] got = '0;
    int nv = 0;
    int first = -1;
    enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c == 0);
      in_data  = 32'h76543210;
      exp_rdy = !rst && (m_fifo.size() < 4);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL single in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL single out c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
      if (dout_valid && nv < 8) begin
        if (first < 0) first = c;
        got = got | (32'(dout) << (4 * nv));
        nv++;
      end
    end
    in_valid = 1'b0;
    total++; if (got !== 32'h76543210 || nv != 8) begin bad++; $display("FAIL single word got=%h n=%0d exp=76543210 n=8", got, nv); end
    total++; if (first != 1) begin bad++; $display("FAIL single latency got=%0d exp=1", first); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    int nv = 0;
    int first = -1;
    int last = -1;
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c < 4);
      in_data  = words[c % 4];
      exp_rdy = !rst && (m_fifo.size() < 4);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL b2b in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL b2b out c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
      if (dout_valid) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
    end
    in_valid = 1'b0;
    total++; if (nv != 32 || (last - first + 1) != 32) begin
      bad++; $display("FAIL b2b contiguous got=%0d span=%0d exp=32", nv, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    enable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = {$urandom_range(0, 65535), 16'(c)};
      if (in_valid && in_ready) acc++;
      exp_rdy = !rst && (m_fifo.size() < 4);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      tick();
      total++; if (dout !== 4'hA || dout_valid !== 1'b0 || busy !== m_busy) begin
        bad++; $display("FAIL bp hold c=%0d got=%h/%b/%b exp=a/0/%b", c, dout, dout_valid, busy, m_busy);
      end
    end
    in_valid = 1'b0;
    total++; if (acc != 4) begin bad++; $display("FAIL bp accepted got=%0d exp=4", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp full in_ready got=%b exp=0", in_ready); end
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      exp_rdy = !rst && (m_fifo.size() < 4);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp drain in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL bp drain c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
    end
  endtask

  task automatic test_enable_drop();
    int nv = 0;
    enable = 1'b1;
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 2);
      in_data  = (c == 0) ? 32'hFEDCBA98 : 32'h13579BDF;
      if (c == 5) enable = 1'b0;  // dout is showing slice 3 of the first word
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL endrop c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
      if (dout_valid) nv++;
    end
    in_valid = 1'b0;
    total++; if (nv != 8) begin bad++; $display("FAIL endrop slices got=%0d exp=8", nv); end
    total++; if (busy !== 1'b1 || dout !== 4'hA) begin bad++; $display("FAIL endrop queued got=%b/%h exp=1/a", busy, dout); end
    enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL endrop resume c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w_new = $urandom;
    logic [31:0] got = '0;
    int nv = 0;
    enable = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 3);
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b0;
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL rstmid pre got=%b exp=1", dout_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (dout !== 4'h0 || dout_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid async got=%h/%b exp=0/0", dout, dout_valid);
    end
    tick();
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid release busy/in_ready got=%b/%b exp=0/1", busy, in_ready);
    end
    for (int c = 0; c < 12; c++) begin
      in_valid = (c == 0);
      in_data  = w_new;
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL rstmid after c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
      if (dout_valid && nv < 8) begin
        got = got | (32'(dout) << (4 * nv));
        nv++;
      end
    end
    in_valid = 1'b0;
    total++; if (got !== w_new || nv != 8) begin bad++; $display("FAIL rstmid word got=%h exp=%h", got, w_new); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      enable   = ($urandom_range(0, 3) != 0);
      in_data  = $urandom;
      exp_rdy = !rst && (m_fifo.size() < 4);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL rand out c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    for (int c = 0; c < 45; c++) tick();
    total++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin bad++; $display("FAIL rand drain got=%b/%b exp=0/0", busy, dout_valid); end
  endtask

`ifdef TX_GEARBOX_PRBS_EN
  task automatic test_prbs();
    logic [3:0] first_val;
    rst = 1'b1;
    prbs_mode = 1'b1;
    enable = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 140; c++) begin
      in_valid = (c == 20);
      in_data  = 32'hC0FFEE42;
      tick();
      if (c == 0) first_val = dout;
      total++; if (dout !== m_dout || dout_valid !== 1'b0 || busy !== m_busy) begin
        bad++; $display("FAIL prbs c=%0d got=%h/%b/%b exp=%h/0/%b", c, dout, dout_valid, busy, m_dout, m_busy);
      end
      if (c == 127) begin
        total++; if (dout !== first_val) begin bad++; $display("FAIL prbs period got=%h exp=%h", dout, first_val); end
      end
    end
    in_valid  = 1'b0;
    prbs_mode = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      total++; if (dout !== m_dout || dout_valid !== m_valid || busy !== m_busy) begin
        bad++; $display("FAIL prbs exit c=%0d got=%h/%b/%b exp=%h/%b/%b", c, dout, dout_valid, busy, m_dout, m_valid, m_busy);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_word();
    test_random();
`ifdef TX_GEARBOX_PRBS_EN
    test_prbs();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tx_word_gearbox.md
Name: tx_word_gearbox

Overview:
- Upstream feeder for the TX data lane: accepts wide parallel words from the link layer over a valid/ready handshake and buffers them in a small FIFO.
- Emits one SER_WIDTH-bit slice per clk cycle on dout, which drives the serializer din of the TX data path. clk is the slowest divided serializer clock.
- Inserts a programmable idle pattern whenever no data is available.

Parameters:
- IN_WIDTH, 32, input word width; must be an integer multiple of SER_WIDTH.
- SER_WIDTH, 2**`SERDES_STAGES, slice width; equals serializer din width.
- FIFO_DEPTH, 4, number of IN_WIDTH words buffered; power of two, ≥2.

Ports:
- clk  input  1  divided serializer clock; all logic on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- enable  input  1  permits draining the FIFO onto dout.
- in_data  input  IN_WIDTH  word from the link layer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept a word this cycle.
- idle_pattern  input  SER_WIDTH  slice driven when not sending data; treated as quasi-static.
- dout  output  SER_WIDTH  slice to the serializer din; registered.
- dout_valid  output  1  dout carries payload, not idle or training data; registered.
- busy  output  1  FIFO non-empty or a word is mid-emission.

Behaviour:
- Reset values (async, while rst=1): dout=0, dout_valid=0, FIFO pointers and count=0, slice index=0, state=IDLE, in_ready=0. After rst deasserts, in_ready=1.
- FIFO push: in_valid && in_ready at a rising edge.
- in_ready is combinational and equals (count != FIFO_DEPTH) && !rst. A pop in the same cycle does not raise in_ready while full; no write-through.
- RATIO = IN_WIDTH/SER_WIDTH. The slice index counts 0..RATIO-1 and wraps. Slice k = word[k*SER_WIDTH +: SER_WIDTH], LSB slice first, matching the serializer's LSB-first bit order.
- State IDLE:
  - dout=idle_pattern, dout_valid=0.
  - If enable && FIFO non-empty at an edge: pop the head word into the shift register, drive slice 0 with dout_valid=1, go to SEND.
- State SEND:
  - Each edge advances to the next slice.
  - At the last slice's edge: if enable && FIFO non-empty, pop and emit slice 0 of the next word with no gap. Otherwise go to IDLE.
- Latency: a word accepted at edge E0 appears as slice 0 on dout after edge E1 at the earliest, if the FIFO was empty and in IDLE.
- enable deasserted mid-word: the current word completes all RATIO slices, then the block goes to IDLE. enable only gates word-boundary pops.
- Empty FIFO at a word boundary: idle_pattern is inserted and dout_valid=0. This is not an error.
- Simultaneous push and pop with count=FIFO_DEPTH-1 or below: count is unchanged and both succeed.
- busy = (count != 0) || (state == SEND).
- Reset mid-word: the word is discarded, the FIFO is flushed, and dout goes to 0 immediately.

Optional Feature:
- Macro: TX_GEARBOX_PRBS_EN.
- When defined:
  - Adds input prbs_mode (1 bit) and a PRBS7 generator (x^7+x^6+1, Fibonacci, seed 7'h7F on reset).
  - prbs_mode is sampled only at word boundaries and in IDLE.
  - While in PRBS mode, dout = next SER_WIDTH PRBS bits, oldest bit in the LSB, and dout_valid=0.
  - The FIFO is not popped, but still accepts pushes.
  - The LFSR advances SER_WIDTH bits per cycle only while in PRBS mode.
- When undefined: no port, no LFSR; behaves as prbs_mode=0.

Test Plan:
All scenarios use IN_WIDTH=32, SER_WIDTH=4, FIFO_DEPTH=4, idle_pattern=4'hA.
1. Release reset, enable=1, push one word 32'h76543210 → dout=4'hA/valid=0 until the edge after the push, then slices 0,1,2,...,7 with dout_valid=1 on 8 consecutive cycles, then 4'hA with valid=0; busy falls with the return to IDLE.
2. enable=1, push 4 words back-to-back (32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444) → 32 consecutive valid slices with no idle gap between words; each word's slices appear in LSB-first order.
3. enable=0, in_valid held high with distinct words → exactly 4 accepted, then in_ready=0 and dout stays 4'hA. Raise enable → in_ready returns to 1 after the first pop; words emerge in push order.
4. enable dropped during slice 3 of 32'hFEDCBA98 with a second word queued → slices 8,9,A,B,C,D,E,F are all emitted; next cycle is 4'hA; the second word stays queued (busy=1) until enable rises.
5. rst pulsed during slice 5 with 2 words queued → dout=0 and dout_valid=0 asynchronously; after release, busy=0 and in_ready=1; a new word is emitted from slice 0.
6. (TX_GEARBOX_PRBS_EN) prbs_mode=1 from reset → dout matches a PRBS7 reference model 4 bits per cycle, with dout_valid=0 and the sequence repeating after 127 cycles; set prbs_mode=0 with a word queued → data resumes at the next word boundary.
